// File: rtl/rom_load_pkg.sv
// Shared types and default ZigZag ROM image layout for the ROM load sequencer.
package rom_load_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        FAIL
    } state_t;

    typedef enum logic [1:0] {
        R_NONE,
        R_PROG,
        R_GFX,
        R_PROM
    } region_t;

    localparam int ADDR_W = 25;

    localparam int ZZ_PROG_SIZE   = 16384;
    localparam int ZZ_GFX_SIZE    = 4096;
    localparam int ZZ_PROM_SIZE   = 32;
    localparam int ZZ_HOLD_CYCLES = 1024;

endpackage

// File: rtl/rom_load_if.sv
// ioctl download stream in, region write port out.
interface rom_load_if;
    import rom_load_pkg::*;

    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;

    logic [15:0]       dn_addr;
    logic [7:0]        dn_data;
    logic              prog_we;
    logic              gfx_we;
    logic              prom_we;

    modport master (
        output ioctl_download,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        input  dn_addr,
        input  dn_data,
        input  prog_we,
        input  gfx_we,
        input  prom_we
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        output dn_addr,
        output dn_data,
        output prog_we,
        output gfx_we,
        output prom_we
    );

endinterface

// File: rtl/rom_region_decode.sv
// Image byte offset to ROM region plus region-relative address.
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter int PROG_SIZE = ZZ_PROG_SIZE,
    parameter int GFX_SIZE  = ZZ_GFX_SIZE,
    parameter int PROM_SIZE = ZZ_PROM_SIZE
) (
    input  logic [ADDR_W-1:0] addr,
    output region_t           region,
    output logic [15:0]       offset
);

    localparam logic [ADDR_W-1:0] B_GFX  = ADDR_W'(PROG_SIZE);
    localparam logic [ADDR_W-1:0] B_PROM = ADDR_W'(PROG_SIZE + GFX_SIZE);
    localparam logic [ADDR_W-1:0] B_END  =
        ADDR_W'(PROG_SIZE + GFX_SIZE + PROM_SIZE);

    always_comb begin
        region = R_NONE;
        offset = '0;
        unique case (1'b1)
            (addr < B_GFX): begin
                region = R_PROG;
                offset = addr[15:0];
            end
            (addr >= B_GFX && addr < B_PROM): begin
                region = R_GFX;
                offset = 16'(addr - B_GFX);
            end
            (addr >= B_PROM && addr < B_END): begin
                region = R_PROM;
                offset = 16'(addr - B_PROM);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rom_load_sequencer.sv
// Routes the HPS ROM download into the core ROM regions and owns core reset.
module rom_load_sequencer
    import rom_load_pkg::*;
#(
    parameter int PROG_SIZE   = ZZ_PROG_SIZE,
    parameter int GFX_SIZE    = ZZ_GFX_SIZE,
    parameter int PROM_SIZE   = ZZ_PROM_SIZE,
    parameter int HOLD_CYCLES = ZZ_HOLD_CYCLES
) (
    input  logic        clk_sys,
    input  logic        reset,
    rom_load_if.slave   bus,
    input  logic        user_reset,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] byte_count
);

    localparam int TOT = PROG_SIZE + GFX_SIZE + PROM_SIZE;
    localparam int HW  = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] TOT_A     = ADDR_W'(TOT);

    state_t        state;
    logic          dl_q;
    logic [HW-1:0] hold_cnt;
    region_t       region;
    logic [15:0]   offset;
    logic [15:0]   dn_addr_q;
    logic [7:0]    dn_data_q;
    logic          prog_q;
    logic          gfx_q;
    logic          prom_q;
    logic          rise;
    logic          fall;
    logic [15:0]   cnt_nx;
    logic          err_nx;

    rom_region_decode #(
        .PROG_SIZE (PROG_SIZE),
        .GFX_SIZE  (GFX_SIZE),
        .PROM_SIZE (PROM_SIZE)
    ) u_decode (
        .addr   (bus.ioctl_addr),
        .region (region),
        .offset (offset)
    );

    assign rise = bus.ioctl_download & ~dl_q;
    assign fall = ~bus.ioctl_download & dl_q;

    // Count and error as they stand after this cycle's byte, if any
    always_comb begin
        cnt_nx = byte_count;
        err_nx = load_err;
        if (bus.ioctl_wr) begin
            if (byte_count != 16'hFFFF) cnt_nx = byte_count + 16'd1;
            if (region == R_NONE ||
                bus.ioctl_addr != {{(ADDR_W-16){1'b0}}, byte_count})
                err_nx = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            hold_cnt   <= '0;
            dn_addr_q  <= '0;
            dn_data_q  <= '0;
            prog_q     <= 1'b0;
            gfx_q      <= 1'b0;
            prom_q     <= 1'b0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            byte_count <= '0;
        end else begin
            dl_q   <= bus.ioctl_download;
            prog_q <= 1'b0;
            gfx_q  <= 1'b0;
            prom_q <= 1'b0;
            if (rise && state != LOAD) begin
                state      <= LOAD;
                core_reset <= 1'b1;
                load_done  <= 1'b0;
                load_err   <= 1'b0;
                byte_count <= '0;
            end else begin
                unique case (state)
                    IDLE, FAIL: core_reset <= 1'b1;
                    LOAD: begin
                        if (bus.ioctl_wr) begin
                            dn_addr_q <= offset;
                            dn_data_q <= bus.ioctl_dout;
                            prog_q    <= (region == R_PROG);
                            gfx_q     <= (region == R_GFX);
                            prom_q    <= (region == R_PROM);
                        end
                        byte_count <= cnt_nx;
                        load_err   <= err_nx;
                        if (fall) begin
                            if ({{(ADDR_W-16){1'b0}}, cnt_nx} == TOT_A &&
                                !err_nx) begin
                                state    <= HOLD;
                                hold_cnt <= '0;
                            end else begin
                                state    <= FAIL;
                                load_err <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state      <= RUN;
                            load_done  <= 1'b1;
                            core_reset <= user_reset;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    RUN: core_reset <= user_reset;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dn_addr = dn_addr_q;
    assign bus.dn_data = dn_data_q;
    assign bus.prog_we = prog_q;
    assign bus.gfx_we  = gfx_q;
    assign bus.prom_we = prom_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Directed bench for rom_load_sequencer at the default ZigZag sizes.
module tb_rom_load_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        user_reset;
    logic        core_reset;
    logic        load_done;
    logic        load_err;
    logic [15:0] byte_count;

    int checks   = 0;
    int failures = 0;
    int n_prog   = 0;
    int n_gfx    = 0;
    int n_prom   = 0;
    int n_multi  = 0;

    rom_load_if bus();

    rom_load_sequencer dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bus        (bus),
        .user_reset (user_reset),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_err   (load_err),
        .byte_count (byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (bus.prog_we === 1'b1) n_prog++;
        if (bus.gfx_we === 1'b1) n_gfx++;
        if (bus.prom_we === 1'b1) n_prom++;
        if ((int'(bus.prog_we) + int'(bus.gfx_we) +
             int'(bus.prom_we)) > 1) n_multi++;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One byte per cycle; data is the low address byte xor 8'h5A
    task automatic send_bytes(input int first, input int last,
                              input int skip);
        for (int a = first; a <= last; a++) begin
            if (a != skip) begin
                bus.ioctl_addr = 25'(a);
                bus.ioctl_dout = 8'(a) ^ 8'h5A;
                bus.ioctl_wr   = 1'b1;
                tick();
                if (a == 16383) begin
                    chk("b16383_prog_we", bus.prog_we, 1);
                    chk("b16383_dn_addr", bus.dn_addr, 16383);
                    chk("b16383_dn_data", bus.dn_data, 32'hA5);
                end
                if (a == 16384) begin
                    chk("b16384_gfx_we", bus.gfx_we, 1);
                    chk("b16384_prog_we", bus.prog_we, 0);
                    chk("b16384_dn_addr", bus.dn_addr, 0);
                end
                if (a == 20480) begin
                    chk("b20480_prom_we", bus.prom_we, 1);
                    chk("b20480_dn_addr", bus.dn_addr, 0);
                    chk("b20480_dn_data", bus.dn_data, 32'h5A);
                end
                if (a == 20511) begin
                    chk("b20511_prom_we", bus.prom_we, 1);
                    chk("b20511_dn_addr", bus.dn_addr, 31);
                end
                if (a == 20512) begin
                    chk("b20512_no_we",
                        {bus.prog_we, bus.gfx_we, bus.prom_we}, 0);
                    chk("b20512_err", load_err, 1);
                end
                if (skip == 100 && a == 99) chk("gap_pre_err", load_err, 0);
                if (skip == 100 && a == 101) chk("gap_err", load_err, 1);
            end
        end
        bus.ioctl_wr = 1'b0;
    endtask

    initial begin
        int p0;
        int g0;
        int r0;
        int bad;
        int hi;

        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        reset              = 1'b1;
        user_reset         = 1'b0;
        tick();
        tick();
        chk("rst_core_reset", core_reset, 1);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_byte_count", byte_count, 0);
        chk("rst_dn_addr", bus.dn_addr, 0);
        chk("rst_dn_data", bus.dn_data, 0);
        chk("rst_we", {bus.prog_we, bus.gfx_we, bus.prom_we}, 0);
        reset = 1'b0;
        tick();

        // reset in the middle of a load
        bus.ioctl_download = 1'b1;
        tick();
        send_bytes(0, 4999, -1);
        chk("mid_count", byte_count, 5000);
        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        chk("midrst_count", byte_count, 0);
        chk("midrst_core_reset", core_reset, 1);
        chk("midrst_err", load_err, 0);
        chk("midrst_dn_addr", bus.dn_addr, 0);
        chk("midrst_dn_data", bus.dn_data, 0);

        // writes while idle are ignored
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = '0;
        bus.ioctl_dout = 8'h11;
        tick();
        chk("idle_wr_we", bus.prog_we, 0);
        tick();
        bus.ioctl_wr = 1'b0;
        chk("idle_wr_count", byte_count, 0);
        chk("idle_wr_data", bus.dn_data, 0);

        // download already high as reset releases, then a short load
        bus.ioctl_download = 1'b1;
        reset              = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send_bytes(0, 19999, -1);
        chk("short_count", byte_count, 20000);
        chk("short_err_pre", load_err, 0);
        bus.ioctl_download = 1'b0;
        tick();
        chk("short_core_reset", core_reset, 1);
        chk("short_load_done", load_done, 0);
        chk("short_err", load_err, 1);
        user_reset = 1'b1;
        tick();
        tick();
        user_reset = 1'b0;
        tick();
        chk("fail_ureset", core_reset, 1);

        // good load
        p0 = n_prog;
        g0 = n_gfx;
        r0 = n_prom;
        bus.ioctl_download = 1'b1;
        tick();
        chk("good_entry_err", load_err, 0);
        chk("good_entry_count", byte_count, 0);
        send_bytes(0, 20511, -1);
        chk("good_count", byte_count, 20512);
        chk("good_err", load_err, 0);
        bus.ioctl_download = 1'b0;
        tick();
        bad = 0;
        for (int c = 1; c < 1024; c++) begin
            tick();
            if (core_reset !== 1'b1 || load_done !== 1'b0) bad++;
        end
        chk("hold_reset_high", bad, 0);
        tick();
        chk("run_core_reset", core_reset, 0);
        chk("run_load_done", load_done, 1);
        chk("good_prog_we", n_prog - p0, 16384);
        chk("good_gfx_we", n_gfx - g0, 4096);
        chk("good_prom_we", n_prom - r0, 32);
        chk("multi_we", n_multi, 0);

        // user reset pulse in RUN
        user_reset = 1'b1;
        chk("ureset_delay", core_reset, 0);
        hi = 0;
        repeat (3) begin
            tick();
            if (core_reset === 1'b1) hi++;
        end
        user_reset = 1'b0;
        chk("ureset_high", hi, 3);
        tick();
        chk("ureset_release", core_reset, 0);

        // new download from RUN, with a gap at byte 100
        bus.ioctl_download = 1'b1;
        tick();
        chk("reload_core_reset", core_reset, 1);
        chk("reload_load_done", load_done, 0);
        send_bytes(0, 20512, 100);
        chk("gap_count", byte_count, 20512);
        bus.ioctl_download = 1'b0;
        tick();
        chk("gap_core_reset", core_reset, 1);
        chk("gap_load_done", load_done, 0);
        chk("gap_final_err", load_err, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
